// File: rtl/zeroskip_pkg.sv
// rtl/zeroskip_pkg.sv - shared types and zero test for the zeroskip bit-mask encoder
package zeroskip_pkg;

  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef enum logic [1:0] {
    COLLECT,
    FINAL,
    EMIT
  } zs_state_e;

  // Sign bit is ignored so that -0 compresses away like +0.
  function automatic logic is_zero(input fp16_t v);
    return (v[FP16_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/zeroskip_cmap_trunc.sv
// rtl/zeroskip_cmap_trunc.sv - keeps the lowest BIT_NONZERO lanes of a union mask and maps them to slots
module zeroskip_cmap_trunc #(
  parameter int BIT_NONZERO   = 8,
  parameter int BIT_GROUPSIZE = 16,
  parameter int IDX_W         = $clog2(BIT_GROUPSIZE)
) (
  input  logic [BIT_GROUPSIZE-1:0]            i_umask,
  output logic [BIT_GROUPSIZE-1:0]            o_cmap,
  output logic [BIT_NONZERO-1:0][IDX_W-1:0]   o_idx,
  output logic [BIT_NONZERO-1:0]              o_slot_vld,
  output logic                                o_ovf
);

  int w_n_set;

  // w_n_set is the rank of the current lane among set lanes; rank k fills slot k.
  always_comb begin
    o_cmap     = '0;
    o_idx      = '0;
    o_slot_vld = '0;
    w_n_set    = 0;
    for (int l = 0; l < BIT_GROUPSIZE; l++) begin
      if (i_umask[l]) begin
        for (int k = 0; k < BIT_NONZERO; k++) begin
          if (w_n_set == k) begin
            o_cmap[l]     = 1'b1;
            o_idx[k]      = IDX_W'(l);
            o_slot_vld[k] = 1'b1;
          end
        end
        w_n_set = w_n_set + 1;
      end
    end
    o_ovf = (w_n_set > BIT_NONZERO);
  end

endmodule

// File: rtl/sparse_zeroskip_bit_kernel_pack.sv
// rtl/sparse_zeroskip_bit_kernel_pack.sv - buffers a tile of dense groups, builds one shared cmap, emits packed groups
module sparse_zeroskip_bit_kernel_pack
  import zeroskip_pkg::*;
#(
  parameter int BIT_NONZERO   = 8,
  parameter int BIT_GROUPSIZE = 16,
  parameter int DATA_W        = FP16_W,
  parameter int N             = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [BIT_GROUPSIZE-1:0][DATA_W-1:0]    in_data,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BIT_GROUPSIZE-1:0]                out_cmap,
  output logic [BIT_NONZERO-1:0][DATA_W-1:0]      out_data,
  output logic                                    out_last,
  output logic                                    ovf,
  output logic                                    ovf_sticky
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam int ROW_W = $clog2(N);
  localparam int IDX_W = $clog2(BIT_GROUPSIZE);

  zs_state_e                                r_state;
  logic                                     r_in_ready;
  logic                                     r_out_valid;
  logic [BIT_GROUPSIZE-1:0]                 r_umask;
  logic [CNT_W-1:0]                         r_rcnt;
  logic [CNT_W-1:0]                         r_ecnt;
  logic [CNT_W-1:0]                         r_rows;
  logic [BIT_GROUPSIZE-1:0]                 r_cmap;
  logic [BIT_NONZERO-1:0][IDX_W-1:0]        r_idx;
  logic [BIT_NONZERO-1:0]                   r_vld;
  logic                                     r_ovf;
  logic                                     r_ovf_sticky;
  logic [BIT_GROUPSIZE-1:0][DATA_W-1:0]     r_buf [N];

  logic [BIT_GROUPSIZE-1:0]                 w_nzmask;
  logic                                     w_in_hs;
  logic                                     w_out_hs;
  logic                                     w_last_beat;
  logic [BIT_GROUPSIZE-1:0]                 w_cmap;
  logic [BIT_NONZERO-1:0][IDX_W-1:0]        w_idx;
  logic [BIT_NONZERO-1:0]                   w_vld;
  logic                                     w_ovf;
  logic [BIT_GROUPSIZE-1:0][DATA_W-1:0]     w_row;

  always_comb begin
    w_nzmask = '0;
    for (int l = 0; l < BIT_GROUPSIZE; l++) begin
      w_nzmask[l] = !is_zero(in_data[l]);
    end
  end

  assign w_in_hs     = r_in_ready && in_valid;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_last_beat = (r_ecnt == r_rows - 1'b1);

  zeroskip_cmap_trunc #(
    .BIT_NONZERO   (BIT_NONZERO),
    .BIT_GROUPSIZE (BIT_GROUPSIZE),
    .IDX_W         (IDX_W)
  ) u_cmap_trunc (
    .i_umask    (r_umask),
    .o_cmap     (w_cmap),
    .o_idx      (w_idx),
    .o_slot_vld (w_vld),
    .o_ovf      (w_ovf)
  );

  // Row storage needs no reset: it is only read back after being written this tile.
  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_buf[r_rcnt[ROW_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= COLLECT;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_umask      <= '0;
      r_rcnt       <= '0;
      r_ecnt       <= '0;
      r_rows       <= '0;
      r_cmap       <= '0;
      r_idx        <= '0;
      r_vld        <= '0;
      r_ovf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_in_hs) begin
            r_umask <= r_umask | w_nzmask;
            // rcnt stays on the final row index so rows = rcnt + 1.
            if (in_last || (r_rcnt == CNT_W'(N - 1))) begin
              r_state    <= FINAL;
              r_in_ready <= 1'b0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        FINAL: begin
          r_cmap      <= w_cmap;
          r_idx       <= w_idx;
          r_vld       <= w_vld;
          r_ovf       <= w_ovf;
          if (w_ovf) begin
            r_ovf_sticky <= 1'b1;
          end
          r_rows      <= r_rcnt + 1'b1;
          r_umask     <= '0;
          r_state     <= EMIT;
          r_out_valid <= 1'b1;
        end
        EMIT: begin
          if (w_out_hs) begin
            if (w_last_beat) begin
              r_state     <= COLLECT;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_rcnt      <= '0;
              r_ecnt      <= '0;
            end else begin
              r_ecnt <= r_ecnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

  always_comb begin
    w_row    = r_buf[r_ecnt[ROW_W-1:0]];
    out_data = '0;
    for (int k = 0; k < BIT_NONZERO; k++) begin
      out_data[k] = r_vld[k] ? w_row[r_idx[k]] : '0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_cmap   = r_cmap;
  assign out_last   = r_out_valid && w_last_beat;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_sparse_zeroskip_bit_kernel_pack.sv
// tb/tb_sparse_zeroskip_bit_kernel_pack.sv - directed self-checking bench for the zeroskip packer
module tb_sparse_zeroskip_bit_kernel_pack;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][15:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_cmap;
  logic [7:0][15:0]  out_data;
  logic              out_last;
  logic              ovf;
  logic              ovf_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] g_tile [8][16];
  int          g_lanes [8];
  int          g_nl;
  logic [15:0] g_cmap;
  logic        g_sticky;

  sparse_zeroskip_bit_kernel_pack #(
    .BIT_NONZERO   (8),
    .BIT_GROUPSIZE (16),
    .DATA_W        (16),
    .N             (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cmap   (out_cmap),
    .out_data   (out_data),
    .out_last   (out_last),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tile();
    for (int r = 0; r < 8; r++)
      for (int l = 0; l < 16; l++)
        g_tile[r][l] = 16'h0000;
  endtask

  task automatic push(input int rows, input bit use_last);
    for (int r = 0; r < rows; r++) begin
      check($sformatf("in_ready_collect_r%0d", r), in_ready, 1);
      in_valid = 1'b1;
      in_last  = use_last && (r == rows - 1);
      for (int l = 0; l < 16; l++) in_data[l] = g_tile[r][l];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("in_ready_final", in_ready, 0);
    check("out_valid_final", out_valid, 0);
  endtask

  task automatic recv(input int rows, input int stop, input bit bp, input int exp_ovf);
    int b;
    int cyc;
    int novf;
    bit hs;
    b = 0;
    cyc = 0;
    novf = 0;
    @(negedge clk);
    check("latency_out_valid", out_valid, 1);
    while (b < stop && cyc < 400) begin
      if (ovf) novf++;
      check($sformatf("out_valid_b%0d", b), out_valid, 1);
      check($sformatf("in_ready_emit_b%0d", b), in_ready, 0);
      check($sformatf("out_cmap_b%0d", b), out_cmap, g_cmap);
      check($sformatf("out_last_b%0d", b), out_last, (b == rows - 1));
      for (int k = 0; k < 8; k++)
        check($sformatf("out_data_b%0d_s%0d", b, k), out_data[k],
              (k < g_nl) ? g_tile[b][g_lanes[k]] : 16'h0000);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = out_valid && out_ready;
      @(negedge clk);
      cyc++;
      if (hs) b++;
    end
    out_ready = 1'b0;
    check("beat_count", b, stop);
    if (stop == rows) begin
      check("in_ready_done", in_ready, 1);
      check("out_valid_done", out_valid, 0);
      check("ovf_pulses", novf, exp_ovf);
      check("ovf_sticky", ovf_sticky, g_sticky);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    g_sticky  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_cmap", out_cmap, 0);
    check("rst_out_data", |out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 8-group tile without in_last; lanes 0, 3, 15 nonzero.
    clear_tile();
    for (int r = 0; r < 8; r++) begin
      g_tile[r][0]  = 16'h0100 + 16'(r);
      g_tile[r][3]  = 16'h0300 + 16'(r);
      g_tile[r][15] = 16'h0F00 + 16'(r);
    end
    g_lanes = '{0, 3, 15, 0, 0, 0, 0, 0};
    g_nl    = 3;
    g_cmap  = 16'h8009;
    push(8, 1'b0);
    recv(8, 8, 1'b0, 0);

    // Union of 9 lanes: lane 13 is dropped and ovf pulses once.
    clear_tile();
    for (int l = 0; l <= 4; l++)  g_tile[0][l] = 16'h4000 + 16'(l);
    for (int l = 10; l <= 13; l++) g_tile[5][l] = 16'h5000 + 16'(l);
    g_lanes  = '{0, 1, 2, 3, 4, 10, 11, 12};
    g_nl     = 8;
    g_cmap   = 16'h1C1F;
    g_sticky = 1'b1;
    push(6, 1'b1);
    recv(6, 6, 1'b0, 1);

    // Negative zeros everywhere except lane 7.
    for (int r = 0; r < 8; r++)
      for (int l = 0; l < 16; l++)
        g_tile[r][l] = (l == 7) ? 16'h3C00 : 16'h8000;
    g_lanes = '{7, 0, 0, 0, 0, 0, 0, 0};
    g_nl    = 1;
    g_cmap  = 16'h0080;
    push(8, 1'b1);
    recv(8, 8, 1'b0, 0);

    // Early in_last on the 3rd group.
    clear_tile();
    for (int r = 0; r < 3; r++) begin
      g_tile[r][2] = 16'hA000 + 16'(r);
      g_tile[r][9] = 16'hA900 + 16'(r);
    end
    g_lanes = '{2, 9, 0, 0, 0, 0, 0, 0};
    g_nl    = 2;
    g_cmap  = 16'h0204;
    push(3, 1'b1);
    recv(3, 3, 1'b0, 0);

    // Single-row tile.
    clear_tile();
    g_tile[0][15] = 16'hBC00;
    g_lanes = '{15, 0, 0, 0, 0, 0, 0, 0};
    g_nl    = 1;
    g_cmap  = 16'h8000;
    push(1, 1'b1);
    recv(1, 1, 1'b0, 0);

    // All-zero tile.
    clear_tile();
    g_nl   = 0;
    g_cmap = 16'h0000;
    push(2, 1'b1);
    recv(2, 2, 1'b0, 0);

    // Random backpressure.
    clear_tile();
    for (int r = 0; r < 8; r++) begin
      g_tile[r][1]  = 16'h1100 + 16'(r);
      g_tile[r][6]  = 16'h1600 + 16'(r);
      g_tile[r][8]  = 16'h1800 + 16'(r);
      g_tile[r][14] = 16'h1E00 + 16'(r);
    end
    g_lanes = '{1, 6, 8, 14, 0, 0, 0, 0};
    g_nl    = 4;
    g_cmap  = 16'h4142;
    push(8, 1'b0);
    recv(8, 8, 1'b1, 0);

    // Reset after 2 of 8 beats, then a clean tile.
    clear_tile();
    for (int r = 0; r < 8; r++) begin
      g_tile[r][4] = 16'h2400 + 16'(r);
      g_tile[r][5] = 16'h2500 + 16'(r);
    end
    g_lanes = '{4, 5, 0, 0, 0, 0, 0, 0};
    g_nl    = 2;
    g_cmap  = 16'h0030;
    push(8, 1'b0);
    recv(8, 2, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_ovf_sticky", ovf_sticky, 0);
    check("midrst_out_cmap", out_cmap, 0);
    g_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_tile();
    g_tile[0][9] = 16'h0009;
    g_tile[1][9] = 16'h8019;
    g_lanes = '{9, 0, 0, 0, 0, 0, 0, 0};
    g_nl    = 1;
    g_cmap  = 16'h0200;
    push(2, 1'b1);
    recv(2, 2, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_zeroskip_bit_kernel_pack.md
Name: sparse_zeroskip_bit_kernel_pack

Overview:
- Encoder side of the zeroskip bit-mask format. Accepts up to N dense groups of BIT_GROUPSIZE values, which form one tile.
- Builds the single cmap shared by all groups of the tile. The cmap has at most BIT_NONZERO set bits.
- Emits each group compacted to BIT_NONZERO slots, in ascending lane order.
- Sits between the weight/activation producer and the compressed-tile store consumed by the zeroskip index decoders.

Parameters:
- BIT_NONZERO, 8, max nonzero lanes per group (packed slots).
- BIT_GROUPSIZE, 16, lanes per group (cmap width).
- DATA_W, FP16_W (16), element width.
- N, 8, max groups per tile sharing one cmap.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  dense group valid.
- in_ready  out  1  block can accept a group.
- in_data  in  [BIT_GROUPSIZE-1:0][DATA_W-1:0]  dense group; lane i = element i.
- in_last  in  1  final group of tile; may end a tile early (<N groups).
- out_valid  out  1  packed group valid.
- out_ready  in  1  downstream accepts.
- out_cmap  out  BIT_GROUPSIZE  tile cmap; bit i set = lane i kept.
- out_data  out  [BIT_NONZERO-1:0][DATA_W-1:0]  packed slots.
- out_last  out  1  final packed group of tile.
- ovf  out  1  one-cycle pulse: tile union had >BIT_NONZERO nonzero lanes.
- ovf_sticky  out  1  set by ovf, cleared only by reset.

Behaviour:
- Zero test: element is zero iff bits [DATA_W-2:0]==0, so +0 and -0 (16'h8000) are both zero.
- Reset values: state COLLECT; in_ready=1; out_valid=0; out_last=0; out_cmap=0; out_data=0; ovf=0; ovf_sticky=0. Buffer contents are don't-care. Reset mid-tile discards the tile with no partial output.
- FSM states: COLLECT, FINAL, EMIT.
- COLLECT:
  - in_ready=1.
  - On each handshake, write in_data to buffer row rcnt and OR the nonzero lane mask into umask.
  - Increment rcnt.
  - Go to FINAL when in_last=1 or rcnt==N-1 at the handshake. The N-th group ends the tile even if in_last=0.
- FINAL (exactly 1 cycle):
  - in_ready=0.
  - Register cmap = umask restricted to its lowest BIT_NONZERO set bits (lanes ascending).
  - Register slot index k = lane of the (k+1)-th set bit of the cmap; unused slots are flagged empty.
  - Pulse ovf if popcount(umask)>BIT_NONZERO; the dropped lanes are lost.
  - Store rows=rcnt+1, clear umask, go to EMIT.
- EMIT:
  - out_valid=1.
  - out_data[k] = buffer[ecnt][idx[k]], or 0 for an empty slot.
  - out_cmap is constant for the whole tile.
  - out_last = (ecnt==rows-1).
  - ecnt advances on the out handshake only. Outputs are stable while out_valid && !out_ready.
  - After the last handshake: go to COLLECT, rcnt=ecnt=0, out_valid=0 on the next cycle.
- Latency: the first out_valid is asserted 2 cycles after the final input handshake.
- Throughput: a tile of R groups needs at least 2R+1 cycles.
- No input acceptance in FINAL or EMIT (no overlap).
- All-zero tile: cmap=0; every output beat has all slots 0.
- in_last=1 on the first group: 1-row tile.
- Counters are $clog2(N)+1 bits wide, so they never wrap within a tile.

Decomposition:
- Package zeroskip_pkg:
  - FP16_W=16.
  - fp16_t typedef.
  - zs_state_e enum {COLLECT, FINAL, EMIT}.
  - Function is_zero(fp16_t).
- One sub-module, zeroskip_cmap_trunc (combinational):
  - Input: umask.
  - Outputs: truncated cmap, BIT_NONZERO slot indices, slot-valid bits, overflow flag.
  - Instantiated in FINAL with registered outputs.

Test Plan:
- Full tile, 8 groups, nonzeros only at lanes 0, 3, 15 (distinct values) -> out_cmap=16'h8009; slots 0..2 = lanes 0, 3, 15 of each group; slots 3..7 = 0; out_last on beat 8; ovf=0.
- Group 0 nonzero lanes 0-4, group 5 nonzero lanes 10-13 -> umask=16'h3C1F (9 bits), out_cmap=16'h1C1F, lane 13 dropped, ovf pulses once, ovf_sticky=1.
- All lanes 16'h8000 except lane 7=16'h3C00 in every group -> out_cmap=16'h0080, slot0=16'h3C00, slots 1..7 = 0.
- in_last on 3rd group -> exactly 3 output beats, out_last on 3rd; in_ready=0 from FINAL until 1 cycle after the 3rd out handshake.
- Random out_ready backpressure (~50%) -> out_data, out_cmap and out_last are held stable while stalled; in_ready stays 0; beat order is preserved.
- rst_n low after 2 of 8 EMIT beats -> out_valid=0 and in_ready=1 immediately; ovf_sticky=0; the next tile encodes correctly with no residue from the old umask.
